axi_sram: RTL
=============

# axi_sram

AXI4 responder (slave) memory that terminates the CPU core's 64-bit AXI4 master port in simulation and FPGA builds, providing instruction and data storage. Independent read and write engines each accept one transaction at a time. Both engines support INCR/FIXED bursts up to 256 beats, byte strobes and narrow sizes. Accesses outside the mapped window return SLVERR.

## Interface
- ADDR_BASE, 32'h8000_0000, byte address of word 0.
- DEPTH_LOG2, 12, log2 of the number of 64-bit words (default 32 KiB).
- RD_LAT, 1, cycles from AR handshake to the first R beat; must be ≥1.

Ports:
- clock  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- awready_o out 1 / awvalid_i in 1 / awaddr_i in 32 / awid_i in 4 / awlen_i in 8 / awsize_i in 3 / awburst_i in 2  write address channel
- wready_o out 1 / wvalid_i in 1 / wdata_i in 64 / wstrb_i in 8 / wlast_i in 1  write data channel
- bready_i in 1 / bvalid_o out 1 / bresp_o out 2 / bid_o out 4  write response channel
- arready_o out 1 / arvalid_i in 1 / araddr_i in 32 / arid_i in 4 / arlen_i in 8 / arsize_i in 3 / arburst_i in 2  read address channel
- rready_i in 1 / rvalid_o out 1 / rresp_o out 2 / rdata_o out 64 / rlast_o out 1 / rid_o out 4  read data channel

## Operation
- Word index = (addr − ADDR_BASE) >> 3. A beat is in range iff ADDR_BASE ≤ addr < ADDR_BASE + 8·2^DEPTH_LOG2. The memory array is not cleared by reset.
- Write FSM W_IDLE → W_DATA → W_RESP → W_IDLE.
  - W_IDLE: awready_o=1. An AW handshake latches id, addr, len, size and burst, clears the beat counter and the error flag.
  - W_DATA: wready_o=1. Each W handshake writes byte lanes i where wstrb_i[i]=1, only when the beat is in range. After each beat the address advances by 1<<size for INCR and holds for FIXED.
  - The burst ends on beat number awlen+1; wlast_i does not control termination.
  - W_RESP: bvalid_o=1, bid_o=latched id. It holds until bready_i, then returns to W_IDLE.
- Read FSM R_IDLE → R_WAIT → R_DATA → R_IDLE.
  - R_IDLE: arready_o=1. An AR handshake latches the fields. R_WAIT is skipped when RD_LAT=1.
  - R_WAIT counts RD_LAT−1 cycles.
  - R_DATA: rvalid_o=1, rid_o=latched id. rdata_o is the full 64-bit word at the current address, or 0 when out of range. rresp_o is OKAY or SLVERR per beat. rlast_o=1 on beat arlen+1.
  - On each R handshake the address advances as for writes. After the last beat the FSM returns to R_IDLE.
- Error rules:
  - Write: bresp_o=SLVERR(2'b10) if any beat was out of range, or awsize>3, or awburst is WRAP/reserved, or wlast_i disagrees with the beat count on any beat. Otherwise OKAY(2'b00).
  - Read: per beat, the same conditions apply (excluding the wlast check). An erroring read beat returns rdata_o=0.
  - Writes flagged by size or burst errors are dropped entirely, but the burst still completes.
- Address arithmetic is 32-bit and wraps modulo 2^32; beats crossing the window end become out-of-range individually.
- Read/write collision on the same word in the same cycle: R shows the old data that cycle and the new data from the next cycle (combinational array read).

## Timing
- While reset=1 and in the first cycle after reset deasserts, all outputs read 0: readies, valids, resp, id, rdata, rlast.
- From the second cycle after reset, awready_o=arready_o=1.
- AW handshake in cycle N → wready_o=1 in N+1. The last W handshake in M → bvalid_o=1 in M+1. The B handshake in K → awready_o=1 in K+1.
- AR handshake in N → first rvalid_o in N+RD_LAT.
- With rready_i held high, one beat issues per cycle. R outputs are stable while rvalid_o=1 and rready_i=0.
- The read and write engines run concurrently and independently; there is no arbitration between them.
- Reset asserted mid-burst aborts both FSMs to idle next cycle; partially written data remains in memory.

## Test plan
- Single write, then read: AW addr 0x8000_0010 len 0 size 3, W data 0x1122334455667788 strb 0xFF → B OKAY id echoed. AR at the same address → rdata 0x1122334455667788, rlast=1, OKAY, first rvalid exactly RD_LAT cycles after AR.
- Strobed INCR burst: AW 0x8000_0000 len 3, strb 0x0F on all beats over a pre-filled 0xFF.. region → read back len 3 shows upper 4 bytes 0xFFFFFFFF and lower bytes = written data, with rlast only on beat 4.
- rready backpressure: read len 7 with rready toggling 1,0,0,1… → exactly 8 beats, data stable during stalls, rlast on the 8th.
- Out-of-range and boundary: write len 1 starting at the last in-range word → bresp SLVERR, last word written, nothing aliased. Read at 0x7FFF_FFF8 → rdata 0, SLVERR.
- Protocol error: awburst=WRAP, or wlast asserted on beat 2 of a len-3 burst → SLVERR after exactly 4 beats, memory unchanged for the WRAP case.
- Concurrency and reset: overlapping read and write bursts complete with correct ids. Assert reset mid-write-burst → next cycle bvalid/wready=0, awready=1 after 2 cycles.

Source files
------------

// File: rtl/axi_sram.sv
// axi_sram: AXI4 responder memory with independent single-outstanding read and write engines.
// INCR/FIXED bursts up to 256 beats, byte strobes, narrow sizes; beats outside the window get SLVERR.
module axi_sram #(
    parameter logic [31:0] ADDR_BASE  = 32'h8000_0000,
    parameter int unsigned DEPTH_LOG2 = 12,
    parameter int unsigned RD_LAT     = 1
) (
    input  logic        clock,
    input  logic        reset,
    output logic        awready_o,
    input  logic        awvalid_i,
    input  logic [31:0] awaddr_i,
    input  logic [3:0]  awid_i,
    input  logic [7:0]  awlen_i,
    input  logic [2:0]  awsize_i,
    input  logic [1:0]  awburst_i,
    output logic        wready_o,
    input  logic        wvalid_i,
    input  logic [63:0] wdata_i,
    input  logic [7:0]  wstrb_i,
    input  logic        wlast_i,
    input  logic        bready_i,
    output logic        bvalid_o,
    output logic [1:0]  bresp_o,
    output logic [3:0]  bid_o,
    output logic        arready_o,
    input  logic        arvalid_i,
    input  logic [31:0] araddr_i,
    input  logic [3:0]  arid_i,
    input  logic [7:0]  arlen_i,
    input  logic [2:0]  arsize_i,
    input  logic [1:0]  arburst_i,
    input  logic        rready_i,
    output logic        rvalid_o,
    output logic [1:0]  rresp_o,
    output logic [63:0] rdata_o,
    output logic        rlast_o,
    output logic [3:0]  rid_o
);
    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;
    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_WAIT = 2'd1;
    localparam logic [1:0] R_DATA = 2'd2;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam int unsigned WORDS      = 1 << DEPTH_LOG2;
    localparam logic [15:0] WAIT_LAST  = 16'(RD_LAT - 2);

    logic [63:0] mem [WORDS];

    // Outputs stay quiet while reset is high and for one cycle after it drops.
    logic out_en_q, out_en_d, out_en;

    logic [1:0]  wstate_q, wstate_d;
    logic [3:0]  awid_q, awid_d;
    logic [31:0] waddr_q, waddr_d;
    logic [7:0]  awlen_q, awlen_d;
    logic [2:0]  awsize_q, awsize_d;
    logic [1:0]  awburst_q, awburst_d;
    logic [7:0]  wcnt_q, wcnt_d;
    logic        werr_q, werr_d;

    logic [1:0]  rstate_q, rstate_d;
    logic [3:0]  arid_q, arid_d;
    logic [31:0] raddr_q, raddr_d;
    logic [7:0]  arlen_q, arlen_d;
    logic [2:0]  arsize_q, arsize_d;
    logic [1:0]  arburst_q, arburst_d;
    logic [7:0]  rcnt_q, rcnt_d;
    logic [15:0] lat_cnt_q, lat_cnt_d;

    logic [31:0]           woff, roff;
    logic [DEPTH_LOG2-1:0] w_idx, r_idx;
    logic                  w_in_range, w_cfg_err, w_last, w_hs, mem_we;
    logic                  r_in_range, r_err, r_last, r_hs;

    always_comb begin
        out_en = out_en_q & ~reset;
        out_en_d = 1'b1;

        woff       = waddr_q - ADDR_BASE;
        w_in_range = (woff >> (DEPTH_LOG2 + 3)) == '0;
        w_idx      = DEPTH_LOG2'(woff >> 3);
        w_cfg_err  = (awsize_q > 3'd3) || (awburst_q > BURST_INCR);
        w_last     = wcnt_q == awlen_q;

        roff       = raddr_q - ADDR_BASE;
        r_in_range = (roff >> (DEPTH_LOG2 + 3)) == '0;
        r_idx      = DEPTH_LOG2'(roff >> 3);
        r_err      = ~r_in_range || (arsize_q > 3'd3) || (arburst_q > BURST_INCR);
        r_last     = rcnt_q == arlen_q;

        awready_o = out_en && (wstate_q == W_IDLE);
        wready_o  = out_en && (wstate_q == W_DATA);
        bvalid_o  = out_en && (wstate_q == W_RESP);
        bresp_o   = bvalid_o ? (werr_q ? RESP_SLVERR : RESP_OKAY) : '0;
        bid_o     = bvalid_o ? awid_q : '0;

        arready_o = out_en && (rstate_q == R_IDLE);
        rvalid_o  = out_en && (rstate_q == R_DATA);
        rdata_o   = (rvalid_o && !r_err) ? mem[r_idx] : '0;
        rresp_o   = (rvalid_o && r_err) ? RESP_SLVERR : RESP_OKAY;
        rlast_o   = rvalid_o && r_last;
        rid_o     = rvalid_o ? arid_q : '0;

        w_hs   = wvalid_i && wready_o;
        r_hs   = rvalid_o && rready_i;
        mem_we = w_hs && w_in_range && !w_cfg_err;
    end

    always_comb begin
        wstate_d  = wstate_q;
        awid_d    = awid_q;
        waddr_d   = waddr_q;
        awlen_d   = awlen_q;
        awsize_d  = awsize_q;
        awburst_d = awburst_q;
        wcnt_d    = wcnt_q;
        werr_d    = werr_q;
        case (wstate_q)
            W_IDLE: begin
                if (awvalid_i && awready_o) begin
                    awid_d    = awid_i;
                    waddr_d   = awaddr_i;
                    awlen_d   = awlen_i;
                    awsize_d  = awsize_i;
                    awburst_d = awburst_i;
                    wcnt_d    = '0;
                    werr_d    = 1'b0;
                    wstate_d  = W_DATA;
                end
            end
            W_DATA: begin
                // Beat count alone ends the burst; a misplaced wlast only flags the response.
                if (w_hs) begin
                    werr_d  = werr_q || !w_in_range || w_cfg_err || (wlast_i != w_last);
                    waddr_d = (awburst_q == BURST_FIXED) ? waddr_q : waddr_q + (32'd1 << awsize_q);
                    wcnt_d  = wcnt_q + 8'd1;
                    if (w_last) wstate_d = W_RESP;
                end
            end
            W_RESP: begin
                if (bvalid_o && bready_i) wstate_d = W_IDLE;
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    always_comb begin
        rstate_d  = rstate_q;
        arid_d    = arid_q;
        raddr_d   = raddr_q;
        arlen_d   = arlen_q;
        arsize_d  = arsize_q;
        arburst_d = arburst_q;
        rcnt_d    = rcnt_q;
        lat_cnt_d = lat_cnt_q;
        case (rstate_q)
            R_IDLE: begin
                if (arvalid_i && arready_o) begin
                    arid_d    = arid_i;
                    raddr_d   = araddr_i;
                    arlen_d   = arlen_i;
                    arsize_d  = arsize_i;
                    arburst_d = arburst_i;
                    rcnt_d    = '0;
                    lat_cnt_d = '0;
                    rstate_d  = (RD_LAT <= 1) ? R_DATA : R_WAIT;
                end
            end
            R_WAIT: begin
                if (lat_cnt_q == WAIT_LAST) rstate_d = R_DATA;
                else lat_cnt_d = lat_cnt_q + 16'd1;
            end
            R_DATA: begin
                if (r_hs) begin
                    raddr_d = (arburst_q == BURST_FIXED) ? raddr_q : raddr_q + (32'd1 << arsize_q);
                    rcnt_d  = rcnt_q + 8'd1;
                    if (r_last) rstate_d = R_IDLE;
                end
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out_en_q  <= 1'b0;
            wstate_q  <= W_IDLE;
            awid_q    <= '0;
            waddr_q   <= '0;
            awlen_q   <= '0;
            awsize_q  <= '0;
            awburst_q <= '0;
            wcnt_q    <= '0;
            werr_q    <= 1'b0;
            rstate_q  <= R_IDLE;
            arid_q    <= '0;
            raddr_q   <= '0;
            arlen_q   <= '0;
            arsize_q  <= '0;
            arburst_q <= '0;
            rcnt_q    <= '0;
            lat_cnt_q <= '0;
        end else begin
            out_en_q  <= out_en_d;
            wstate_q  <= wstate_d;
            awid_q    <= awid_d;
            waddr_q   <= waddr_d;
            awlen_q   <= awlen_d;
            awsize_q  <= awsize_d;
            awburst_q <= awburst_d;
            wcnt_q    <= wcnt_d;
            werr_q    <= werr_d;
            rstate_q  <= rstate_d;
            arid_q    <= arid_d;
            raddr_q   <= raddr_d;
            arlen_q   <= arlen_d;
            arsize_q  <= arsize_d;
            arburst_q <= arburst_d;
            rcnt_q    <= rcnt_d;
            lat_cnt_q <= lat_cnt_d;
        end
    end

    // Array contents survive reset; the read port is combinational, so same-cycle collisions see old data.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            for (int unsigned i = 0; i < 8; i++) begin
                if (wstrb_i[i]) mem[w_idx][8*i +: 8] <= wdata_i[8*i +: 8];
            end
        end
    end
endmodule
